// File: rtl/globefish_qspi_pkg.sv
// rtl/globefish_qspi_pkg.sv - shared constants, state enum and byte-select helpers for the QSPI XIP controller
package globefish_qspi_pkg;

    localparam logic [7:0] OP_READ  = 8'hEB;
    localparam logic [7:0] OP_WRITE = 8'h38;
    localparam int CMD_LEN  = 8;
    localparam int ADDR_LEN = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_DONE,
        ST_GAP
    } qspi_state_e;

    function automatic logic [1:0] sel_low(input logic [3:0] sel);
        logic [1:0] lo;
        lo = 2'd0;
        if (sel[0])      lo = 2'd0;
        else if (sel[1]) lo = 2'd1;
        else if (sel[2]) lo = 2'd2;
        else if (sel[3]) lo = 2'd3;
        return lo;
    endfunction

    function automatic logic [2:0] sel_count(input logic [3:0] sel);
        return 3'(sel[0]) + 3'(sel[1]) + 3'(sel[2]) + 3'(sel[3]);
    endfunction

    // Non-zero and a single run of ones.
    function automatic logic sel_valid(input logic [3:0] sel);
        logic ok;
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b0110, 4'b1100,
            4'b0111, 4'b1110, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/globefish_qspi_shreg.sv
// rtl/globefish_qspi_shreg.sv - serial-out shift register (single/quad) and quad-in byte-lane assembler
module globefish_qspi_shreg
    import globefish_qspi_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        shift,
    input  logic        quad,
    input  logic        capture,
    input  logic [3:0]  ser_in,
    output logic [3:0]  ser_out,
    output logic [31:0] rx_word
);

    logic [31:0] tx;
    logic [31:0] rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx <= 32'h0;
            rx <= 32'h0;
        end else begin
            if (load)
                tx <= load_val;
            else if (shift)
                tx <= quad ? {tx[27:0], 4'h0} : {tx[30:0], 1'b0};
            if (capture)
                rx <= {rx[27:0], ser_in};
        end
    end

    assign ser_out = quad ? tx[31:28] : {3'b000, tx[31]};
    // The first byte received lands in rx[31:24]; swapping puts it on lane 0.
    assign rx_word = bswap32(rx);

endmodule

// File: rtl/globefish_qspi_xip.sv
// rtl/globefish_qspi_xip.sv - Wishbone to QSPI execute-in-place controller for flash ROM and PSRAM
module globefish_qspi_xip
    import globefish_qspi_pkg::*;
#(
    parameter int ROM_DUMMY = 6,
    parameter int RAM_DUMMY = 6
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [24:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        qspi_mem_cs_rom_on,
    output logic        qspi_mem_cs_ram_on,
    output logic        qspi_mem_sck_o,
    output logic [3:0]  qspi_mem_sd_o,
    output logic [3:0]  qspi_mem_oen_o,
    input  logic [3:0]  qspi_mem_sd_i
);

    qspi_state_e state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic        sck_d, ack_d, err_d;
    logic        latch;

    logic        ram_q, we_q, bad_q;
    logic [23:0] addr_q;
    logic [31:0] wdat_q;
    logic [2:0]  n_q;

    logic        req, req_bad;
    logic [1:0]  req_lo;
    logic [7:0]  dummy_len;
    logic        in_txn;

    logic        tx_load, tx_shift, rx_cap, quad;
    logic [31:0] tx_val;
    logic [3:0]  shreg_sd;

    assign req       = wb_cyc_i & wb_stb_i;
    assign req_lo    = sel_low(wb_sel_i);
    assign req_bad   = !sel_valid(wb_sel_i) || (wb_we_i && !wb_adr_i[24]);
    assign dummy_len = ram_q ? 8'(RAM_DUMMY) : 8'(ROM_DUMMY);
    assign quad      = (state != ST_CMD);
    assign in_txn    = (state == ST_CMD) || (state == ST_ADDR) ||
                       (state == ST_DUMMY) || (state == ST_DATA);

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state          <= ST_IDLE;
            cnt            <= 8'd0;
            qspi_mem_sck_o <= 1'b0;
            wb_ack_o       <= 1'b0;
            wb_err_o       <= 1'b0;
            ram_q          <= 1'b0;
            we_q           <= 1'b0;
            bad_q          <= 1'b0;
            addr_q         <= 24'h0;
            wdat_q         <= 32'h0;
            n_q            <= 3'd0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            qspi_mem_sck_o <= sck_d;
            wb_ack_o       <= ack_d;
            wb_err_o       <= err_d;
            if (latch) begin
                ram_q  <= wb_adr_i[24];
                we_q   <= wb_we_i;
                bad_q  <= req_bad;
                addr_q <= (wb_adr_i[23:0] & 24'hFFFFFC) | {22'h0, req_lo};
                // Pre-arrange write bytes so the lowest enabled lane leaves first.
                wdat_q <= bswap32(wb_dat_i >> {req_lo, 3'b000});
                n_q    <= sel_count(wb_sel_i);
            end
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        sck_d    = 1'b0;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        latch    = 1'b0;
        tx_load  = 1'b0;
        tx_val   = 32'h0;
        tx_shift = 1'b0;
        rx_cap   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    latch = 1'b1;
                    if (req_bad) begin
                        state_d = ST_DONE;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = ST_CMD;
                        cnt_d   = 8'(CMD_LEN - 1);
                        tx_load = 1'b1;
                        tx_val  = {(wb_we_i ? OP_WRITE : OP_READ), 24'h0};
                    end
                end
            end
            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                sck_d = !qspi_mem_sck_o;
                // Everything advances on the edge that ends the SCK high phase.
                if (qspi_mem_sck_o) begin
                    rx_cap = (state == ST_DATA) && !we_q;
                    if (cnt != 8'd0) begin
                        cnt_d    = cnt - 8'd1;
                        tx_shift = 1'b1;
                    end else if (state == ST_CMD) begin
                        state_d = ST_ADDR;
                        cnt_d   = 8'(ADDR_LEN - 1);
                        tx_load = 1'b1;
                        tx_val  = {addr_q, 8'h0};
                    end else if (state == ST_ADDR) begin
                        if (we_q) begin
                            state_d = ST_DATA;
                            cnt_d   = {4'h0, n_q, 1'b0} - 8'd1;
                            tx_load = 1'b1;
                            tx_val  = wdat_q;
                        end else if (dummy_len != 8'd0) begin
                            state_d = ST_DUMMY;
                            cnt_d   = dummy_len - 8'd1;
                        end else begin
                            state_d = ST_DATA;
                            cnt_d   = 8'd7;
                        end
                    end else if (state == ST_DUMMY) begin
                        state_d = ST_DATA;
                        cnt_d   = 8'd7;
                    end else begin
                        state_d = ST_DONE;
                        cnt_d   = 8'd1;
                    end
                end
            end
            ST_DONE: begin
                if (cnt == 8'd0) begin
                    state_d = ST_GAP;
                    ack_d   = !bad_q;
                    err_d   = bad_q;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        qspi_mem_sd_o  = 4'h0;
        qspi_mem_oen_o = 4'h0;
        case (state)
            ST_CMD: begin
                qspi_mem_sd_o  = shreg_sd;
                qspi_mem_oen_o = 4'b0001;
            end
            ST_ADDR: begin
                qspi_mem_sd_o  = shreg_sd;
                qspi_mem_oen_o = 4'b1111;
            end
            ST_DATA: begin
                if (we_q) begin
                    qspi_mem_sd_o  = shreg_sd;
                    qspi_mem_oen_o = 4'b1111;
                end
            end
            default: ;
        endcase
    end

    assign qspi_mem_cs_rom_on = !(in_txn && !ram_q);
    assign qspi_mem_cs_ram_on = !(in_txn && ram_q);

    globefish_qspi_shreg u_shreg (
        .clk      (clk_i),
        .rst_n    (rst_in),
        .load     (tx_load),
        .load_val (tx_val),
        .shift    (tx_shift),
        .quad     (quad),
        .capture  (rx_cap),
        .ser_in   (qspi_mem_sd_i),
        .ser_out  (shreg_sd),
        .rx_word  (wb_dat_o)
    );

endmodule

// File: tb/tb_globefish_qspi_xip.sv
// tb/tb_globefish_qspi_xip.sv - table-driven bench with a QSPI flash/PSRAM device model
module tb_globefish_qspi_xip;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [24:0] adr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] dat_w = '0;
    logic [31:0] dat_r;
    logic        ack, err;
    logic        cs_rom_n, cs_ram_n, sck;
    logic [3:0]  sd_o, oen;
    logic [3:0]  sd_i = 4'h0;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc_cnt = 0;

    globefish_qspi_xip #(.ROM_DUMMY(6), .RAM_DUMMY(6)) dut (
        .clk_i(clk), .rst_in(rst_n),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_w),
        .wb_dat_o(dat_r), .wb_ack_o(ack), .wb_err_o(err),
        .qspi_mem_cs_rom_on(cs_rom_n), .qspi_mem_cs_ram_on(cs_ram_n),
        .qspi_mem_sck_o(sck), .qspi_mem_sd_o(sd_o), .qspi_mem_oen_o(oen),
        .qspi_mem_sd_i(sd_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // External device model: samples pins once per clk, acts on SCK rising edges.
    logic [7:0]  rom_mem [0:4095];
    logic [7:0]  ram_mem [0:4095];
    logic        active = 1'b0, is_ram = 1'b0, sck_prev = 1'b0;
    int          k = 0, wcount = 0, cs_falls = 0;
    int          oen_viol = 0, sck_viol = 0, gap_viol = 0, hi_run = 0;
    logic        ever_low = 1'b0;
    logic [7:0]  cmd = '0;
    logic [23:0] addr = '0;
    logic [3:0]  hi_nib = '0;
    logic [7:0]  last_cmd = '0;
    logic [23:0] last_addr = '0;
    logic        last_ram = 1'b0;
    int          last_wcount = 0;

    always @(posedge clk) begin
        logic [7:0] b;
        int j;
        #1;
        if (cs_rom_n && cs_ram_n) begin
            if (sck) sck_viol++;
            hi_run++;
            if (active) begin
                last_cmd = cmd; last_addr = addr; last_ram = is_ram; last_wcount = wcount;
            end
            active = 1'b0; k = 0; sd_i = 4'h0;
        end else begin
            if (!active) begin
                if (ever_low && hi_run < 2) gap_viol++;
                active = 1'b1; cs_falls++; is_ram = !cs_ram_n;
                cmd = '0; addr = '0; wcount = 0; ever_low = 1'b1;
            end
            hi_run = 0;
            if (sck && !sck_prev) begin
                if (k < 8) begin
                    if (oen !== 4'b0001) oen_viol++;
                    cmd = {cmd[6:0], sd_o[0]};
                end else if (k < 14) begin
                    if (oen !== 4'b1111) oen_viol++;
                    addr = {addr[19:0], sd_o};
                end else if (cmd == 8'h38) begin
                    if (oen !== 4'b1111) oen_viol++;
                    j = k - 14;
                    if (j % 2 == 0) hi_nib = sd_o;
                    else begin
                        ram_mem[12'(addr[11:0] + 12'(j / 2))] = {hi_nib, sd_o};
                        wcount++;
                    end
                end else begin
                    if (oen !== 4'b0000) oen_viol++;
                    if (k >= 20) begin
                        j = k - 20;
                        b = is_ram ? ram_mem[12'(addr[11:0] + 12'(j / 2))]
                                   : rom_mem[12'(addr[11:0] + 12'(j / 2))];
                        sd_i = (j % 2 == 0) ? b[7:4] : b[3:0];
                    end
                end
                k++;
            end
        end
        sck_prev = sck;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic run_req(input logic r_we, input logic [24:0] r_adr, input logic [3:0] r_sel,
                           input logic [31:0] r_dat, output logic got_ack, output logic got_err,
                           output int lat, output logic [31:0] rd, output logic timeout,
                           output logic extra);
        int t0;
        @(posedge clk); #1;
        we = r_we; adr = r_adr; sel = r_sel; dat_w = r_dat; cyc = 1'b1; stb = 1'b1;
        t0 = cyc_cnt + 1;
        timeout = 1'b1; got_ack = 1'b0; got_err = 1'b0; lat = -1; rd = '0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (ack || err) begin
                got_ack = ack; got_err = err; rd = dat_r; lat = cyc_cnt - t0; timeout = 1'b0;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        extra = ack || err;
    endtask

    typedef struct {
        logic        we;
        logic [24:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        exp_err;
        logic        exp_ram;
        logic [7:0]  exp_cmd;
        logic [23:0] exp_addr;
        logic [31:0] exp_rd;
        int          exp_wbytes;
        int          exp_lat;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        logic        g_ack, g_err, tmo, extra;
        int          lat, falls0, acks, hi_cycles, first_t, second_t;
        logic [31:0] rd;

        for (int i = 0; i < 4096; i++) begin rom_mem[i] = 8'h00; ram_mem[i] = 8'h00; end
        rom_mem[12'h100] = 8'h11; rom_mem[12'h101] = 8'h22;
        rom_mem[12'h102] = 8'h33; rom_mem[12'h103] = 8'h44;

        //            we    adr            sel    dat           err   ram   cmd    addr        rd            wb  lat
        vecs[0] = '{1'b0, 25'h0000100, 4'hF, 32'h0,        1'b0, 1'b0, 8'hEB, 24'h000100, 32'h44332211, 0, 58};
        vecs[1] = '{1'b1, 25'h1000010, 4'h4, 32'h00AB0000, 1'b0, 1'b1, 8'h38, 24'h000012, 32'h0,        1, 34};
        vecs[2] = '{1'b1, 25'h1000020, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 8'h38, 24'h000020, 32'h0,        4, 46};
        vecs[3] = '{1'b0, 25'h1000020, 4'hF, 32'h0,        1'b0, 1'b1, 8'hEB, 24'h000020, 32'hDEADBEEF, 0, 58};
        vecs[4] = '{1'b1, 25'h0000100, 4'hF, 32'h12345678, 1'b1, 1'b0, 8'h00, 24'h0,      32'h0,        0, 2};
        vecs[5] = '{1'b0, 25'h1000020, 4'h5, 32'h0,        1'b1, 1'b1, 8'h00, 24'h0,      32'h0,        0, 2};
        vecs[6] = '{1'b0, 25'h1000010, 4'h4, 32'h0,        1'b0, 1'b1, 8'hEB, 24'h000012, 32'h000000AB, 0, 58};
        vecs[7] = '{1'b1, 25'h1000030, 4'hC, 32'hCAFE5A5A, 1'b0, 1'b1, 8'h38, 24'h000032, 32'h0,        2, 38};
        vecs[8] = '{1'b0, 25'h1000030, 4'hF, 32'h0,        1'b0, 1'b1, 8'hEB, 24'h000030, 32'hCAFE0000, 0, 58};
        vecs[9] = '{1'b0, 25'h0000200, 4'h0, 32'h0,        1'b1, 1'b0, 8'h00, 24'h0,      32'h0,        0, 2};

        repeat (3) @(posedge clk);
        #1;
        check("reset pins", {31'h0, cs_rom_n}, 32'h1);
        check("reset cs_ram", {31'h0, cs_ram_n}, 32'h1);
        check("reset sck/ack/err", {29'h0, sck, ack, err}, 32'h0);
        check("reset sd/oen", {24'h0, sd_o, oen}, 32'h0);
        check("reset dat_o", dat_r, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            falls0 = cs_falls;
            run_req(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, g_ack, g_err, lat, rd, tmo, extra);
            check($sformatf("v%0d response", i), {31'h0, tmo}, 32'h0);
            check($sformatf("v%0d err", i), {31'h0, g_err}, {31'h0, vecs[i].exp_err});
            check($sformatf("v%0d ack", i), {31'h0, g_ack}, {31'h0, !vecs[i].exp_err});
            check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d single pulse", i), {31'h0, extra}, 32'h0);
            if (vecs[i].exp_err) begin
                check($sformatf("v%0d no cs", i), cs_falls - falls0, 0);
            end else begin
                check($sformatf("v%0d opcode", i), {24'h0, last_cmd}, {24'h0, vecs[i].exp_cmd});
                check($sformatf("v%0d address", i), {8'h0, last_addr}, {8'h0, vecs[i].exp_addr});
                check($sformatf("v%0d chip", i), {31'h0, last_ram}, {31'h0, vecs[i].exp_ram});
                if (vecs[i].we)
                    check($sformatf("v%0d write bytes", i), last_wcount, vecs[i].exp_wbytes);
                else
                    check($sformatf("v%0d read data", i), rd, vecs[i].exp_rd);
            end
            repeat (2) @(posedge clk);
        end

        // Reset in the middle of the address phase of a ROM read.
        @(posedge clk); #1;
        we = 1'b0; adr = 25'h0000100; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        repeat (20) @(posedge clk);
        #3;
        check("pre-reset cs_rom active", {31'h0, cs_rom_n}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("async reset cs/sck", {29'h0, cs_rom_n, cs_ram_n, sck}, 32'h6);
        check("async reset sd/oen", {24'h0, sd_o, oen}, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (ack || err) acks++;
        end
        check("dropped txn not acked", acks, 0);
        run_req(1'b0, 25'h0000100, 4'hF, 32'h0, g_ack, g_err, lat, rd, tmo, extra);
        check("post-reset read ack", {30'h0, g_ack, tmo}, 32'h2);
        check("post-reset read data", rd, 32'h44332211);
        check("post-reset latency", lat, 58);

        // Back-to-back reads with stb held.
        @(posedge clk); #1;
        we = 1'b0; adr = 25'h0000100; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        acks = 0; hi_cycles = 0; first_t = -1; second_t = -1;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                hi_cycles++;
                if (acks == 0 || (i != second_t + 1 && i != first_t + 1)) begin
                    acks++;
                    if (acks == 1) first_t = i; else if (acks == 2) second_t = i;
                    check($sformatf("b2b data %0d", acks), dat_r, 32'h44332211);
                end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        check("b2b ack count", acks, 2);
        check("b2b ack high cycles", hi_cycles, 2);
        check("b2b first latency", first_t, 58);
        check("b2b ack spacing", second_t - first_t, 60);
        repeat (80) @(posedge clk);
        #1;

        check("sck low while cs high", sck_viol, 0);
        check("cs high gap >= 2", gap_viol, 0);
        check("oen per phase", oen_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
